// File: rtl/sha256_req_arbiter.sv
// Round-robin arbiter sharing one combinational single-block SHA-256 core among NUM_REQ requesters.
// Optional macro SHA256_DOUBLE_HASH_EN adds req_dbl and a second core pass (SHA256d).
module sha256_req_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned CORE_CYCLES = 2,
    localparam int unsigned ID_W       = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [512*NUM_REQ-1:0] req_msg,
`ifdef SHA256_DOUBLE_HASH_EN
    input  logic [NUM_REQ-1:0]     req_dbl,
`endif
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [ID_W-1:0]        resp_id,
    output logic [255:0]           resp_digest
);

    localparam int unsigned IDX_W = ID_W + 1;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned BLK_W = 512;
    localparam int unsigned DIG_W = 256;

`ifdef SHA256_DOUBLE_HASH_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_HASH = 2'd1, S_RESP = 2'd2, S_HASH2 = 2'd3} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_HASH = 2'd1, S_RESP = 2'd2} state_t;
`endif

    localparam logic [31:0] K_TAB [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [255:0] H_INIT = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // One full compression of a pre-padded block from the standard IV; fully unrolled.
    function automatic logic [255:0] sha256_block(input logic [511:0] blk);
        logic [31:0] w [16];
        logic [31:0] a, b, c, d, e, f, g, h;
        logic [31:0] t1, t2, s0, s1;
        logic [3:0]  j;
        logic [5:0]  r;
        for (int i = 0; i < 16; i++) begin
            w[i] = blk[511 - 32*i -: 32];
        end
        {a, b, c, d, e, f, g, h} = H_INIT;
        for (int i = 0; i < 64; i++) begin
            j = 4'(i);
            r = 6'(i);
            if (i >= 16) begin
                s0 = rotr(w[j + 4'd1], 7) ^ rotr(w[j + 4'd1], 18) ^ (w[j + 4'd1] >> 3);
                s1 = rotr(w[j + 4'd14], 17) ^ rotr(w[j + 4'd14], 19) ^ (w[j + 4'd14] >> 10);
                w[j] = w[j] + s0 + w[j + 4'd9] + s1;
            end
            t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K_TAB[r] + w[j];
            t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g;
            g = f;
            f = e;
            e = d + t1;
            d = c;
            c = b;
            b = a;
            a = t1 + t2;
        end
        return {H_INIT[255:224] + a, H_INIT[223:192] + b, H_INIT[191:160] + c, H_INIT[159:128] + d,
                H_INIT[127:96]  + e, H_INIT[95:64]    + f, H_INIT[63:32]    + g, H_INIT[31:0]     + h};
    endfunction

    state_t             state_q, state_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [BLK_W-1:0]   msg_q, msg_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               resp_valid_q, resp_valid_d;
    logic [ID_W-1:0]    resp_id_q, resp_id_d;
    logic [DIG_W-1:0]   resp_digest_q, resp_digest_d;
`ifdef SHA256_DOUBLE_HASH_EN
    logic               dbl_q, dbl_d;
`endif

    logic [NUM_REQ-1:0] grant_c;
    logic [ID_W-1:0]    gid_c;
    logic [IDX_W-1:0]   sum_c;
    logic               accept_c;
    logic [DIG_W-1:0]   core_digest_c;

    // Core sees only msg_q; the path is constrained as a CORE_CYCLES multicycle path.
    always_comb begin
        core_digest_c = sha256_block(msg_q);
    end

    // Round-robin search from rr_ptr+1; scanning far-to-near lets the nearest valid win.
    always_comb begin
        grant_c = '0;
        gid_c   = '0;
        sum_c   = '0;
        if (state_q == S_IDLE) begin
            for (int k = NUM_REQ; k >= 1; k--) begin
                sum_c = IDX_W'(rr_ptr_q) + IDX_W'(k);
                if (sum_c >= IDX_W'(NUM_REQ)) begin
                    sum_c = sum_c - IDX_W'(NUM_REQ);
                end
                if (req_valid[ID_W'(sum_c)]) begin
                    gid_c = ID_W'(sum_c);
                end
            end
            if (|req_valid) begin
                grant_c[gid_c] = 1'b1;
            end
        end
    end

    assign accept_c = |grant_c;

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        msg_d         = msg_q;
        id_d          = id_q;
        cnt_d         = cnt_q;
        resp_valid_d  = resp_valid_q;
        resp_id_d     = resp_id_q;
        resp_digest_d = resp_digest_q;
`ifdef SHA256_DOUBLE_HASH_EN
        dbl_d         = dbl_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    msg_d    = req_msg[{gid_c, 9'd0} +: BLK_W];
                    id_d     = gid_c;
                    rr_ptr_d = gid_c;
                    cnt_d    = CNT_W'(CORE_CYCLES - 1);
`ifdef SHA256_DOUBLE_HASH_EN
                    dbl_d    = req_dbl[gid_c];
`endif
                    state_d  = S_HASH;
                end
            end
`ifdef SHA256_DOUBLE_HASH_EN
            S_HASH, S_HASH2: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (state_q == S_HASH && dbl_q) begin
                    // Second pass hashes the 32-byte first digest, padded to one block.
                    msg_d   = {core_digest_c, 1'b1, 191'd0, 64'd256};
                    cnt_d   = CNT_W'(CORE_CYCLES - 1);
                    state_d = S_HASH2;
                end else begin
                    resp_digest_d = core_digest_c;
                    resp_id_d     = id_q;
                    resp_valid_d  = 1'b1;
                    state_d       = S_RESP;
                end
            end
`else
            S_HASH: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    resp_digest_d = core_digest_c;
                    resp_id_d     = id_q;
                    resp_valid_d  = 1'b1;
                    state_d       = S_RESP;
                end
            end
`endif
            S_RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            rr_ptr_q      <= ID_W'(NUM_REQ - 1);
            msg_q         <= '0;
            id_q          <= '0;
            cnt_q         <= '0;
            resp_valid_q  <= 1'b0;
            resp_id_q     <= '0;
            resp_digest_q <= '0;
`ifdef SHA256_DOUBLE_HASH_EN
            dbl_q         <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            msg_q         <= msg_d;
            id_q          <= id_d;
            cnt_q         <= cnt_d;
            resp_valid_q  <= resp_valid_d;
            resp_id_q     <= resp_id_d;
            resp_digest_q <= resp_digest_d;
`ifdef SHA256_DOUBLE_HASH_EN
            dbl_q         <= dbl_d;
`endif
        end
    end

    assign req_ready   = grant_c;
    assign resp_valid  = resp_valid_q;
    assign resp_id     = resp_id_q;
    assign resp_digest = resp_digest_q;

endmodule

// File: tb/tb_sha256_req_arbiter.sv
// Directed bench for sha256_req_arbiter (NUM_REQ=4, CORE_CYCLES=2); double-hash step runs when
// SHA256_DOUBLE_HASH_EN is defined.
module tb_sha256_req_arbiter;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned CC      = 2;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NUM_REQ-1:0]     req_valid;
    logic [512*NUM_REQ-1:0] req_msg;
    logic [NUM_REQ-1:0]     req_dbl;
    logic [NUM_REQ-1:0]     req_ready;
    logic                   resp_valid;
    logic                   resp_ready;
    logic [1:0]             resp_id;
    logic [255:0]           resp_digest;

    int n_cmp = 0;
    int n_bad = 0;

    logic [511:0] blk_abc;
    logic [511:0] blk_empty;
    logic [255:0] dig_abc;
    logic [255:0] dig_empty;
    logic [255:0] dig_abc_dbl;
    logic [3:0]   exp_gnt;

    sha256_req_arbiter #(.NUM_REQ(NUM_REQ), .CORE_CYCLES(CC)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_msg     (req_msg),
`ifdef SHA256_DOUBLE_HASH_EN
        .req_dbl     (req_dbl),
`endif
        .req_ready   (req_ready),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_id     (resp_id),
        .resp_digest (resp_digest)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not reach summary");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        blk_abc              = '0;
        blk_abc[511:480]     = 32'h61626380;
        blk_abc[31:0]        = 32'h00000018;
        blk_empty            = '0;
        blk_empty[511:480]   = 32'h80000000;
        dig_abc     = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
        dig_empty   = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
        dig_abc_dbl = 256'h4f8b42c22dd3729b519ba6f68d2da7cc5b2d606d05daed5ad5128cc03e6c6358;

        rst        = 1'b1;
        req_valid  = '0;
        req_dbl    = '0;
        resp_ready = 1'b0;
        req_msg    = {blk_empty, blk_abc, blk_abc, blk_abc};
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("rst_resp_valid", 256'(resp_valid), 256'd0);
        check("rst_resp_id", 256'(resp_id), 256'd0);
        check("rst_resp_digest", resp_digest, 256'd0);
        check("rst_req_ready", 256'(req_ready), 256'd0);

        // Requester 0, "abc"
        req_valid = 4'b0001;
        #1;
        check("t1_grant", 256'(req_ready), 256'(4'b0001));
        tick();
        req_valid = '0;
        #1;
        check("t1_ready_hash", 256'(req_ready), 256'd0);
        check("t1_lat0", 256'(resp_valid), 256'd0);
        tick();
        check("t1_lat1", 256'(resp_valid), 256'd0);
        tick();
        check("t1_valid", 256'(resp_valid), 256'd1);
        check("t1_id", 256'(resp_id), 256'd0);
        check("t1_digest", resp_digest, dig_abc);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check("t1_done", 256'(resp_valid), 256'd0);

        // Requester 3, empty message; consumer stalls 10 clocks
        req_valid = 4'b1000;
        #1;
        check("t2_grant", 256'(req_ready), 256'(4'b1000));
        tick();
        req_valid = '0;
        tick();
        tick();
        check("t2_valid", 256'(resp_valid), 256'd1);
        check("t2_id", 256'(resp_id), 256'd3);
        check("t2_digest", resp_digest, dig_empty);
        req_valid = 4'b0001;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t4_hold_valid", 256'(resp_valid), 256'd1);
            check("t4_hold_id", 256'(resp_id), 256'd3);
            check("t4_hold_digest", resp_digest, dig_empty);
            check("t4_hold_ready", 256'(req_ready), 256'd0);
        end
        req_valid  = '0;
        resp_ready = 1'b1;
        tick();
        check("t4_handshake", 256'(resp_valid), 256'd0);
        check("t4_idle_ready", 256'(req_ready), 256'd0);

        // All requesters valid, consumer always ready: grants 0,1,2,3,0 every CC+2 clocks
        req_valid = 4'b1111;
        #1;
        for (int g = 0; g < 5; g++) begin
            exp_gnt = 4'b0001 << (g % 4);
            check("t3_grant", 256'(req_ready), 256'(exp_gnt));
            tick();
            check("t3_ready_busy0", 256'(req_ready), 256'd0);
            tick();
            check("t3_ready_busy1", 256'(req_ready), 256'd0);
            check("t3_not_early", 256'(resp_valid), 256'd0);
            tick();
            check("t3_valid", 256'(resp_valid), 256'd1);
            check("t3_id", 256'(resp_id), 256'(g % 4));
            check("t3_digest", resp_digest, ((g % 4) == 3) ? dig_empty : dig_abc);
            check("t3_ready_resp", 256'(req_ready), 256'd0);
            tick();
            if (g == 4) req_valid = '0;
        end
        resp_ready = 1'b0;

        // Reset during HASH aborts the hash and restores the pointer
        req_valid = 4'b0010;
        #1;
        check("t5_grant", 256'(req_ready), 256'(4'b0010));
        tick();
        req_valid = '0;
        rst = 1'b1;
        #1;
        check("t5_rst_valid", 256'(resp_valid), 256'd0);
        check("t5_rst_id", 256'(resp_id), 256'd0);
        check("t5_rst_digest", resp_digest, 256'd0);
        check("t5_rst_ready", 256'(req_ready), 256'd0);
        tick();
        rst = 1'b0;
        resp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t5_no_resp", 256'(resp_valid), 256'd0);
        end
        resp_ready = 1'b0;
        req_valid  = 4'b0101;
        #1;
        check("t5_rr_reset_grant", 256'(req_ready), 256'(4'b0001));
        tick();
        req_valid = '0;
        tick();
        tick();
        check("t5_valid", 256'(resp_valid), 256'd1);
        check("t5_id", 256'(resp_id), 256'd0);
        check("t5_digest", resp_digest, dig_abc);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check("t5_done", 256'(resp_valid), 256'd0);

`ifdef SHA256_DOUBLE_HASH_EN
        // Double hash of "abc" from requester 0
        req_dbl   = 4'b0001;
        req_valid = 4'b0001;
        #1;
        check("t6_grant", 256'(req_ready), 256'(4'b0001));
        tick();
        req_valid = '0;
        req_dbl   = '0;
        for (int i = 0; i < 2*CC - 1; i++) begin
            tick();
            check("t6_not_early", 256'(resp_valid), 256'd0);
        end
        tick();
        check("t6_valid", 256'(resp_valid), 256'd1);
        check("t6_id", 256'(resp_id), 256'd0);
        check("t6_digest", resp_digest, dig_abc_dbl);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check("t6_done", 256'(resp_valid), 256'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
